// File: rtl/traffic_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_display_driver
//  Purpose  : Front-panel driver for the traffic controller. Registers the
//             one-hot lamp drives from the 2-bit light code, converts the
//             6-bit countdown to two BCD digits with a sequential
//             shift-add-3 engine, and scans both digits onto a two-digit
//             common-anode seven-segment display.
//  Options  : FAULT_FLASH_EN - when defined, the yellow lamp flashes while
//             the light code is illegal (11); otherwise all lamps stay dark.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_display_driver #(
    parameter int SCAN_DIV  = 16,   // cycles each digit stays enabled (2..65535)
    parameter int BLINK_DIV = 8     // digit toggles per blink phase toggle (1..255)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] led_in,
    input  logic [5:0] timer_in,
    output logic       lamp_red,
    output logic       lamp_green,
    output logic       lamp_yellow,
    output logic       fault,
    output logic [6:0] seg_n,
    output logic [1:0] dig_n,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam logic [15:0] c_scan_last = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  c_last_shift = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Active-low segment pattern for one BCD digit; non-digits blank the display.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------------
    // Lamp decode
    // ------------------------------------------------------------------------
    logic lamp_red_q, lamp_green_q, lamp_yellow_q, fault_q;
    logic lamp_red_d, lamp_green_d, lamp_yellow_d, fault_d;
    logic w_fault_yellow;

    // Decode the light code into one-hot lamp drives; code 11 raises fault.
    always_comb begin
        lamp_red_d    = 1'b0;
        lamp_green_d  = 1'b0;
        lamp_yellow_d = 1'b0;
        fault_d       = 1'b0;
        case (led_in)
            2'b00:   lamp_red_d    = 1'b1;
            2'b01:   lamp_green_d  = 1'b1;
            2'b10:   lamp_yellow_d = 1'b1;
            default: begin
                fault_d       = 1'b1;
                lamp_yellow_d = w_fault_yellow;
            end
        endcase
    end

    // Register the lamp drives so they change one cycle after the code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamp_red_q    <= 1'b0;
            lamp_green_q  <= 1'b0;
            lamp_yellow_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            lamp_red_q    <= lamp_red_d;
            lamp_green_q  <= lamp_green_d;
            lamp_yellow_q <= lamp_yellow_d;
            fault_q       <= fault_d;
        end
    end

    // ------------------------------------------------------------------------
    // Binary to BCD conversion (shift-add-3)
    // shreg layout: [13:10] tens, [9:6] ones, [5:0] binary still to shift in
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [5:0]  last_val_q, last_val_d;
    logic [13:0] shreg_q, shreg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  tens_q, tens_d, ones_q, ones_d;
    logic [13:0] w_adj;

    // Next-state logic: capture a changed value, shift six times, then publish
    // both digits in one cycle so tens/ones never show a half-updated pair.
    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        tens_d     = tens_q;
        ones_d     = ones_q;

        w_adj = shreg_q;
        if (shreg_q[13:10] >= 4'd5) w_adj[13:10] = shreg_q[13:10] + 4'd3;
        if (shreg_q[9:6]   >= 4'd5) w_adj[9:6]   = shreg_q[9:6]   + 4'd3;

        case (state_q)
            S_IDLE: begin
                if (timer_in != last_val_q) begin
                    shreg_d    = {8'd0, timer_in};
                    last_val_d = timer_in;
                    cnt_d      = 3'd0;
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                shreg_d = w_adj << 1;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == c_last_shift) state_d = S_DONE;
            end
            S_DONE: begin
                tens_d  = shreg_q[13:10];
                ones_d  = shreg_q[9:6];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Conversion engine state and published digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_val_q <= 6'd0;
            shreg_q    <= 14'd0;
            cnt_q      <= 3'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    // ------------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------------
    logic [15:0] scnt_q, scnt_d;
    logic        sel_q, sel_d;
    logic        w_scan_wrap;
    logic [6:0]  seg_n_q;
    logic [1:0]  dig_n_q;

    // Scan counter: switch the enabled digit every SCAN_DIV cycles.
    always_comb begin
        w_scan_wrap = (scnt_q == c_scan_last);
        scnt_d      = w_scan_wrap ? 16'd0 : scnt_q + 16'd1;
        sel_d       = w_scan_wrap ? ~sel_q : sel_q;
    end

    // Segments and digit enable are registered together so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q  <= 16'd0;
            sel_q   <= 1'b0;
            seg_n_q <= 7'h7F;
            dig_n_q <= 2'b11;
        end else begin
            scnt_q  <= scnt_d;
            sel_q   <= sel_d;
            seg_n_q <= sel_q ? seg_enc(tens_q) : seg_enc(ones_q);
            dig_n_q <= sel_q ? 2'b01 : 2'b10;
        end
    end

    // ------------------------------------------------------------------------
    // Fault blink
    // ------------------------------------------------------------------------
`ifdef FAULT_FLASH_EN
    logic [7:0] bcnt_q;
    logic       phase_q;

    // Count digit toggles; every BLINK_DIV of them flips the blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= 8'd0;
            phase_q <= 1'b0;
        end else if (w_scan_wrap) begin
            if (bcnt_q == 8'(BLINK_DIV - 1)) begin
                bcnt_q  <= 8'd0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q <= bcnt_q + 8'd1;
            end
        end
    end

    assign w_fault_yellow = phase_q;
`else
    assign w_fault_yellow = 1'b0;
`endif

    assign lamp_red    = lamp_red_q;
    assign lamp_green  = lamp_green_q;
    assign lamp_yellow = lamp_yellow_q;
    assign fault       = fault_q;
    assign seg_n       = seg_n_q;
    assign dig_n       = dig_n_q;
    assign tens        = tens_q;
    assign ones        = ones_q;

endmodule
`default_nettype wire

// File: doc/traffic_display_driver.md
# traffic_display_driver

Front-panel consumer of the traffic controller's `led` code and `timer_value` count. It decodes the 2-bit light code into three registered one-hot lamp drives. It converts the 6-bit countdown to two BCD digits with a sequential shift-add-3 engine. It time-multiplexes those digits onto a two-digit common-anode seven-segment display.

## Interface
Parameters:
- `SCAN_DIV`, default 16: clock cycles each digit stays enabled; legal range 2..65535.
- `BLINK_DIV`, default 8: digit-select toggles per fault-blink phase toggle; legal range 1..255.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `led_in`, input, 2: light code. 00 red, 01 green, 10 yellow, 11 illegal.
- `timer_in`, input, 6: remaining seconds, 0..63.
- `lamp_red`, `lamp_green`, `lamp_yellow`, output, 1 each: active-high lamp drives.
- `fault`, output, 1: registered flag, high while `led_in`==11.
- `seg_n`, output, 7: active-low segments, bit0=a … bit6=g.
- `dig_n`, output, 2: active-low digit enables, bit0=ones, bit1=tens.
- `tens`, `ones`, output, 4 each: converted BCD digits, for debug and observation.

## Operation
- Lamp decode is registered with 1-cycle latency.
  - 00 → red.
  - 01 → green.
  - 10 → yellow.
  - 11 → `fault`=1; lamp behaviour is set under Configuration.
- Conversion FSM has states IDLE, CONV and DONE. Internal regs: `last_val` (6b), `shreg` (14b = 4b tens, 4b ones, 6b bin), `cnt` (3b).
  - IDLE: when `timer_in` ≠ `last_val`, load `shreg`={8'd0, timer_in}, set `last_val`=`timer_in`, `cnt`=0, and go to CONV. Otherwise stay in IDLE.
  - CONV, each cycle: add 3 to any BCD nibble ≥5, then shift `shreg` left 1 and increment `cnt`. After the 6th shift (`cnt`==5 at the edge), go to DONE.
  - DONE: write `tens`/`ones` from `shreg` atomically, then return to IDLE.
  - `timer_in` changes during CONV or DONE are ignored. On return to IDLE the current value is compared against `last_val`, so only the latest value is converted and no intermediate value is required.
  - `tens` ≤ 6 and `ones` ≤ 9 always.
- Scan: `scnt` counts 0..SCAN_DIV-1. At wrap, `sel` toggles.
  - `sel`=0 → `dig_n`=2'b10 with the ones pattern.
  - `sel`=1 → `dig_n`=2'b01 with the tens pattern.
  - `seg_n` and `dig_n` are registered together, so the two outputs never mismatch.
- Segment encoding, 0–9: 40,79,24,30,19,12,02,78,00,10 (hex, active-low).
- Blink: `bcnt` counts `sel` toggles 0..BLINK_DIV-1. At wrap, `phase` toggles.

## Timing
- Reset values:
  - Lamps and `fault`: 0.
  - `seg_n`=7'h7F, `dig_n`=2'b11.
  - `tens`=`ones`=0, `last_val`=0, FSM in IDLE.
  - `scnt`=0, `sel`=0, `bcnt`=0, `phase`=0.
- First edge after reset release: `dig_n`=2'b10, `seg_n`=7'h40.
- Conversion latency: call the IDLE edge that captures a new `timer_in` edge 0. Edges 1–6 are the shifts, and DONE writes on edge 7. New `tens`/`ones` are visible after edge 7.
- Back-to-back changes: worst-case update latency is 15 edges (one value in flight, plus 8 edges for the next).
- A digit display period is SCAN_DIV cycles. A full refresh takes 2·SCAN_DIV cycles. Blink half-period is SCAN_DIV·BLINK_DIV cycles.
- Asserting `rst_n` mid-conversion aborts immediately and restores all reset values. After release, a non-zero `timer_in` triggers a fresh conversion.
- A `led_in` change and a conversion completing on the same edge are independent. Both outputs update on that edge.

## Configuration
- `FAULT_FLASH_EN` defined:
  - On code 11, `lamp_yellow`=`phase`, and red and green are off.
  - The blink counters run continuously.
  - On leaving code 11, lamps follow the decode on the next edge.
- `FAULT_FLASH_EN` undefined:
  - On code 11 all lamps are 0.
  - The blink counter and phase logic are not built.
- `fault` behaves the same in both builds.

## Test plan
- Reset release with `timer_in`=18 → after 8 edges `tens`=1 and `ones`=8; scanning shows `seg_n`=79 on `dig_n`=01 and 00 on `dig_n`=10.
- `timer_in`=63, then 0 → `tens`/`ones`=6/3, then 0/0. Sweeping all 64 values matches a decimal reference.
- `timer_in` changing every cycle 18→17→16 during CONV → final digits 1/6, with no glitch to intermediate values.
- `led_in` 00→01→10 → one-hot lamp follows 1 cycle later each time; `fault` stays 0.
- `led_in`=11 with SCAN_DIV=4 and BLINK_DIV=2 → `fault`=1.
  - With FAULT_FLASH_EN, `lamp_yellow` toggles every 8 cycles.
  - Without FAULT_FLASH_EN, all lamps stay 0.
- `rst_n` pulsed low at edge 3 of a conversion → all outputs return to reset values asynchronously; after release, digits reconverge to the current `timer_in`.
